// File: rtl/dlfloat_host_link.sv
// Host end of the DLFloat MAC pin protocol: sends an operand pair as two pin words
// and rebuilds the byte-serial result (low byte, then high byte) into one 16-bit word.
module dlfloat_host_link #(
    parameter int RES_LAT  = 4,
    parameter bit LO_PHASE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic [15:0] pin_data,
    input  logic [7:0]  pin_res,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        phase
);
    localparam int CW = $clog2(RES_LAT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT   = 3'd3,
        SYNC   = 3'd4,
        CAP_HI = 3'd5
    } state_t;

    state_t         state_reg, state_next;
    logic           phase_reg;
    logic [15:0]    a_reg, b_reg;
    logic [7:0]     lo_reg;
    logic [15:0]    res_data_reg;
    logic           res_valid_reg;
    logic [CW-1:0]  cnt_reg;
    logic           accept;

    assign accept = op_valid && op_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SEND_A;
            SEND_A:  state_next = SEND_B;
            SEND_B:  state_next = WAIT;
            WAIT:    if (cnt_reg == '0) state_next = SYNC;
            SYNC:    if (phase_reg == LO_PHASE) state_next = CAP_HI;
            CAP_HI:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The A word may only be sent on phase 0, so accepts are gated to phase 1.
    always_comb begin
        op_ready = (state_reg == IDLE) && phase_reg;
        busy     = (state_reg != IDLE);
        case (state_reg)
            SEND_A:  pin_data = a_reg;
            SEND_B:  pin_data = b_reg;
            default: pin_data = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg     <= 1'b0;
            a_reg         <= 16'h0000;
            b_reg         <= 16'h0000;
            lo_reg        <= 8'h00;
            res_data_reg  <= 16'h0000;
            res_valid_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            phase_reg     <= ~phase_reg;
            res_valid_reg <= (state_reg == CAP_HI);
            if (accept) begin
                a_reg <= op_a;
                b_reg <= op_b;
            end
            case (state_reg)
                SEND_B: cnt_reg <= CW'(RES_LAT - 1);
                WAIT:   if (cnt_reg != '0) cnt_reg <= cnt_reg - CW'(1);
                SYNC:   if (phase_reg == LO_PHASE) lo_reg <= pin_res;
                CAP_HI: res_data_reg <= {pin_res, lo_reg};
                default: ;
            endcase
        end
    end

    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign phase     = phase_reg;
endmodule

// File: tb/tb_dlfloat_host_link.sv
// Bench for dlfloat_host_link: two instances (default timing and RES_LAT=1/LO_PHASE=1)
// checked every cycle against a cycle-schedule model of the pin protocol.
module tb_dlfloat_host_link;
    localparam int NI = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NI-1:0]        op_valid;
    logic [NI-1:0][15:0]  op_a, op_b;
    logic [NI-1:0][7:0]   pin_res;
    logic [NI-1:0]        op_ready_w, res_valid_w, busy_w, phase_w;
    logic [NI-1:0][15:0]  pin_data_w, res_data_w;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        dlfloat_host_link #(
            .RES_LAT  (gi == 0 ? 4 : 1),
            .LO_PHASE (gi == 0 ? 1'b0 : 1'b1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .op_valid  (op_valid[gi]),
            .op_ready  (op_ready_w[gi]),
            .op_a      (op_a[gi]),
            .op_b      (op_b[gi]),
            .pin_data  (pin_data_w[gi]),
            .pin_res   (pin_res[gi]),
            .res_valid (res_valid_w[gi]),
            .res_data  (res_data_w[gi]),
            .busy      (busy_w[gi]),
            .phase     (phase_w[gi])
        );
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } pair_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    pair_t       plist [NI][64];
    int          head [NI];
    int          tail [NI];
    bit          hv [NI];
    int          gap [NI];
    bit          act [NI];
    int          t0 [NI];
    int          tc [NI];
    pair_t       cur [NI];
    logic [15:0] res_m [NI];

    function automatic int rl_of(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int lp_of(int k);
        return (k == 0) ? 0 : 1;
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(int k, logic [15:0] a, logic [15:0] b, logic [7:0] lo, logic [7:0] hi);
        plist[k][tail[k]] = '{a: a, b: b, lo: lo, hi: hi};
        tail[k]++;
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int k = 0; k < NI; k++)
            if (act[k] || hv[k] || head[k] < tail[k]) p = 1;
        return p;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int k = 0; k < NI; k++) begin
            act[k] = 0; hv[k] = 0; gap[k] = 0; res_m[k] = 16'h0000;
        end
    endtask

    // One cycle: compare outputs with the schedule, then drive host and MAC-side inputs.
    task automatic step();
        for (int k = 0; k < NI; k++) begin
            int c = cyc;
            bit rv = 0, bsy, rdy;
            logic [15:0] pd = 16'h0000;
            if (act[k] && c == tc[k] + 2) begin
                res_m[k] = {cur[k].hi, cur[k].lo};
                rv = 1;
                act[k] = 0;
            end
            bsy = act[k] && c > t0[k] && c <= tc[k] + 1;
            rdy = !bsy && (c % 2 == 1);
            if (act[k] && c == t0[k] + 1) pd = cur[k].a;
            if (act[k] && c == t0[k] + 2) pd = cur[k].b;
            check($sformatf("i%0d c%0d phase", k, c), {15'b0, phase_w[k]}, 16'(c % 2));
            check($sformatf("i%0d c%0d op_ready", k, c), {15'b0, op_ready_w[k]}, {15'b0, rdy});
            check($sformatf("i%0d c%0d busy", k, c), {15'b0, busy_w[k]}, {15'b0, bsy});
            check($sformatf("i%0d c%0d pin_data", k, c), pin_data_w[k], pd);
            check($sformatf("i%0d c%0d res_valid", k, c), {15'b0, res_valid_w[k]}, {15'b0, rv});
            check($sformatf("i%0d c%0d res_data", k, c), res_data_w[k], res_m[k]);
            if (rv) $display("i%0d cycle %0d result %h", k, c, res_data_w[k]);

            if (!hv[k] && head[k] < tail[k]) begin
                if (gap[k] == 0) hv[k] = 1;
                else gap[k]--;
            end
            op_valid[k] = hv[k];
            op_a[k] = hv[k] ? plist[k][head[k]].a : 16'($urandom);
            op_b[k] = hv[k] ? plist[k][head[k]].b : 16'($urandom);
            if (hv[k] && rdy) begin
                int c0 = c + 3 + rl_of(k);
                if (c0 % 2 != lp_of(k)) c0++;
                cur[k] = plist[k][head[k]];
                t0[k] = c;
                tc[k] = c0;
                act[k] = 1;
                head[k]++;
                hv[k] = 0;
                gap[k] = $urandom_range(0, 3);
                $display("i%0d cycle %0d accept a=%h b=%h", k, c, cur[k].a, cur[k].b);
            end
            if (act[k] && c == tc[k]) pin_res[k] = cur[k].lo;
            else if (act[k] && c == tc[k] + 1) pin_res[k] = cur[k].hi;
            else pin_res[k] = 8'($urandom);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(string tag, int budget);
        int n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        check(tag, {15'b0, pending()}, 16'h0000);
    endtask

    task automatic check_reset_outputs(string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s i%0d phase", tag, k), {15'b0, phase_w[k]}, 16'h0000);
            check($sformatf("%s i%0d op_ready", tag, k), {15'b0, op_ready_w[k]}, 16'h0000);
            check($sformatf("%s i%0d busy", tag, k), {15'b0, busy_w[k]}, 16'h0000);
            check($sformatf("%s i%0d pin_data", tag, k), pin_data_w[k], 16'h0000);
            check($sformatf("%s i%0d res_valid", tag, k), {15'b0, res_valid_w[k]}, 16'h0000);
            check($sformatf("%s i%0d res_data", tag, k), res_data_w[k], 16'h0000);
        end
    endtask

    initial begin
        int n;
        op_valid = '0;
        op_a = '0;
        op_b = '0;
        pin_res = '0;
        for (int k = 0; k < NI; k++) begin
            head[k] = 0; tail[k] = 0;
        end
        model_reset();

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset();

        // 1.0 x 2.0 raised on phase 0, then all-ones and all-zeros result bytes, back to back.
        for (int k = 0; k < NI; k++) begin
            push(k, 16'h3E00, 16'h4000, 8'h00, 8'h40);
            push(k, 16'($urandom), 16'($urandom), 8'hFF, 8'hFF);
            push(k, 16'($urandom), 16'($urandom), 8'h00, 8'h00);
        end
        drain("directed_drain", 200);

        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 15; i++)
                push(k, 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
        drain("random_drain", 1000);

        // Abort instance 0 during its WAIT state with an asynchronous reset.
        push(0, 16'h1234, 16'h5678, 8'hAB, 8'hCD);
        push(1, 16'h9ABC, 16'hDEF0, 8'h12, 8'h34);
        n = 0;
        while (!(act[0] && cyc >= t0[0] + 3 && cyc <= t0[0] + 2 + rl_of(0)) && n < 50) begin
            step();
            n++;
        end
        check("reach_wait", {15'b0, n >= 50}, 16'h0000);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        op_valid = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;
        model_reset();
        head[1] = tail[1];

        for (int k = 0; k < NI; k++)
            push(k, 16'h3E00, 16'h3E00, 8'h00, 8'h3E);
        drain("post_reset_drain", 200);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
